// File: rtl/cclimb_rom_loader.sv
// -----------------------------------------------------------------------------
// cclimb_rom_loader
//   Routes the HPS ioctl download stream into the crazy_climber core's dn_*
//   ROM-load port. Each byte is registered and range-checked. An 8-bit additive
//   checksum and a byte count are kept. The core is held in reset during a
//   download, and for RESET_HOLD cycles after the download ends.
//
// Ports
//   clk_sys        system clock; all logic on the rising edge
//   reset_n        asynchronous active-low reset
//   ioctl_download download in progress (level)
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address (25 bits)
//   ioctl_dout     byte data
//   dn_addr        registered ROM address to the core
//   dn_data        registered ROM data to the core
//   dn_wr          one-cycle write strobe to the core
//   core_reset     active-high reset to the core
//   rom_valid      last download was complete and clean
//   overflow       sticky: out-of-range byte seen in the current download
//   byte_count     accepted bytes in the current download (saturates at 65536)
//   checksum       mod-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module cclimb_rom_loader #(
  parameter int ROM_BYTES  = 49152,
  parameter int RESET_HOLD = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_valid,
  output logic        overflow,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
  localparam logic [16:0] ROM_CNT   = 17'(ROM_BYTES);
  localparam logic [16:0] CNT_MAX   = 17'h10000;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } ioctl_req_t;

  state_t            state;
  logic              armed;
  logic [HOLD_W-1:0] hold_cnt;

  ioctl_req_t req;
  logic       start;
  logic       take;
  logic       in_range;
  logic [16:0] cnt_base, cnt_nxt;
  logic [7:0]  sum_base, sum_nxt;
  logic        ovf_base, ovf_nxt;

  assign req = '{addr: ioctl_addr, data: ioctl_dout};

  // A new download can begin from IDLE (only once armed), or it can pre-empt
  // the settle period or a running core.
  assign start = ioctl_download &&
                 ((state == IDLE && armed) || state == HOLD || state == RUN);

  // Strobes only count while download is high, in LOAD or on the entry edge.
  assign take     = ioctl_wr && ioctl_download && (state == LOAD || start);
  assign in_range = (req.addr < ROM_LIMIT);

  // Statistics are cleared on entry first, so an entry-cycle byte counts
  // after the clear.
  always_comb begin
    cnt_base = start ? 17'd0 : byte_count;
    sum_base = start ? 8'd0  : checksum;
    ovf_base = start ? 1'b0  : overflow;
    cnt_nxt  = cnt_base;
    sum_nxt  = sum_base;
    ovf_nxt  = ovf_base;
    if (take) begin
      if (in_range) begin
        cnt_nxt = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 17'd1;
        sum_nxt = sum_base + req.data;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      hold_cnt   <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      core_reset <= 1'b1;
      rom_valid  <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
    end else begin
      // Seeing download low once arms the loader. This means a download that
      // is already running when reset is released never loads.
      armed      <= armed | ~ioctl_download;
      dn_wr      <= 1'b0;
      byte_count <= cnt_nxt;
      checksum   <= sum_nxt;
      overflow   <= ovf_nxt;

      if (take && in_range) begin
        dn_wr   <= 1'b1;
        dn_addr <= req.addr[15:0];
        dn_data <= req.data;
      end

      if (start) begin
        state      <= LOAD;
        core_reset <= 1'b1;
        rom_valid  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (!ioctl_download) begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              if (byte_count != 17'd0) begin
                state      <= RUN;
                core_reset <= 1'b0;
                rom_valid  <= (byte_count == ROM_CNT) && !overflow;
              end else begin
                // Empty download: leave the core parked in reset.
                state <= IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cclimb_rom_loader.md
Name: cclimb_rom_loader

Overview:
Download router between the HPS ioctl stream and the crazy_climber core's dn_* ROM-load port. It registers and range-checks each downloaded byte and keeps an 8-bit additive checksum and a byte count. It holds the core in reset during a download and for a fixed settle period afterwards. The core's reset input is driven from core_reset.

Parameters:
ROM_BYTES, 49152, number of valid ROM bytes; ioctl_addr >= ROM_BYTES is out of range (1..65536).
RESET_HOLD, 1024, clk_sys cycles core_reset stays high after download ends (>= 1).

Ports:
clk_sys  input  1  system clock (48 MHz); all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
ioctl_download  input  1  download in progress (level).
ioctl_wr  input  1  one-cycle byte strobe.
ioctl_addr  input  25  byte address.
ioctl_dout  input  8  byte data.
dn_addr  output  16  registered ROM address to core.
dn_data  output  8  registered ROM data to core.
dn_wr  output  1  one-cycle write strobe to core.
core_reset  output  1  active-high reset to core.
rom_valid  output  1  last download complete and clean.
overflow  output  1  sticky: out-of-range byte seen in the current download.
byte_count  output  17  accepted bytes in the current download.
checksum  output  8  mod-256 sum of accepted bytes.

Behaviour:
- Interface decision: one clock, clk_sys; reset_n is asynchronous and active-low.
- Reset values:
  - State IDLE; armed=0.
  - dn_addr=0, dn_data=0, dn_wr=0, core_reset=1, rom_valid=0, overflow=0, byte_count=0, checksum=0.
  - Hold counter=0.
- States: IDLE, LOAD, HOLD, RUN.
- armed: set when ioctl_download is sampled 0. It is cleared only by reset.
- IDLE:
  - Download start: ioctl_download=1 with armed=1 -> LOAD. On that edge, clear byte_count, checksum, overflow and rom_valid, and force core_reset=1.
  - A strobe on the same cycle as the start is accepted. It counts after the clear.
  - With armed=0, ioctl_download=1 is ignored. A download already running at reset therefore never loads.
- Accept rule (LOAD, or the IDLE->LOAD entry cycle): when ioctl_wr=1 and ioctl_download=1:
  - In range (ioctl_addr < ROM_BYTES, compared at full 25 bits): next edge dn_wr=1, dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout, byte_count+=1, checksum+=ioctl_dout (mod 256).
  - Out of range: dn_wr=0; dn_addr and dn_data hold; overflow<=1.
  - Latency is exactly 1 clk_sys. dn_wr is 0 on every other cycle.
  - Back-to-back strobes give back-to-back dn_wr pulses.
- Strobe gating: ioctl_wr with ioctl_download=0 is ignored in every state, including the cycle the download falls.
- LOAD end: ioctl_download=0 -> HOLD with counter<=RESET_HOLD-1; core_reset stays 1.
- HOLD:
  - Counter decrements each cycle.
  - When counter==0 and byte_count!=0: -> RUN, core_reset<=0, rom_valid<=(byte_count==ROM_BYTES && !overflow).
  - When counter==0 and byte_count==0: -> IDLE, core_reset stays 1.
  - ioctl_download=1 during HOLD: -> LOAD with counters cleared (a new download).
- Hold timing: with RESET_HOLD=N, core_reset falls on the Nth edge after the edge that registered ioctl_download=0.
- RUN: ioctl_download=1 -> LOAD on the next edge. core_reset<=1 and rom_valid<=0 on that same edge.
- Duplicate address: re-written each time; counted each time.
- byte_count: saturates at 65536; checksum wraps.
- Reset mid-download: all outputs return to reset values immediately (async). Entering LOAD then needs ioctl_download low for at least one cycle.

Test Plan:
- Reset release with ioctl_download=0 -> core_reset=1, dn_wr=0, rom_valid=0. Pulse download; write 49152 bytes, data=addr[7:0], at 1 strobe per 4 cycles -> 49152 dn_wr pulses each 1 cycle after the strobe, with matching addr/data. byte_count=49152, checksum=0x00. core_reset falls exactly 1024 cycles after download falls. rom_valid=1.
- Strobes at 0xBFFF, 0xC000 and 0x10000 -> one dn_wr (addr 0xBFFF) only; overflow=1, byte_count=1. After hold: core_reset=0, rom_valid=0.
- Contiguous strobes for 8 cycles at addr 0..7, data 0xFF -> 8 consecutive dn_wr pulses; checksum=0xF8.
- Download rises with a strobe on the same cycle -> byte accepted, byte_count=1. Strobe on the cycle download falls -> no dn_wr.
- Download with 0 strobes -> after hold, state IDLE, core_reset remains 1. Download during RUN -> core_reset=1 and rom_valid=0 on the next edge.
- reset_n pulsed low mid-download with download still high -> outputs at reset values. Further strobes produce no dn_wr until download drops low then rises again.
